// File: rtl/noc_input_port.sv
// noc_input_port: mesh-router input port.
// Computes an XY route for each head or single flit and locks the input onto
// that route until the tail arrives. It buffers flits in one FIFO per
// direction VC. A round-robin arbiter feeds the crossbar and holds its grant
// from head to tail, so packets are never interleaved.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_router_x/y            this router's coordinates (static)
//   i_in_valid/i_in_flit    upstream flit, o_in_ready = port accepts it
//   o_out_valid/o_out_flit  head of granted VC (first-word-fall-through)
//   o_out_dir               granted VC / direction (N0 S1 E2 W3 L4)
//   i_out_ready             crossbar accepts o_out_flit
//   o_occupancy             per-VC fill count, VC i in slice i
//   o_err                   one-cycle pulse after a flit is dropped
module noc_input_port #(
  parameter int unsigned FLIT_W  = 10,
  parameter int unsigned COORD_W = 2,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned NUM_VC  = 5
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic [COORD_W-1:0]                    i_router_x,
  input  logic [COORD_W-1:0]                    i_router_y,
  input  logic                                  i_in_valid,
  input  logic [FLIT_W-1:0]                     i_in_flit,
  output logic                                  o_in_ready,
  output logic                                  o_out_valid,
  output logic [FLIT_W-1:0]                     o_out_flit,
  output logic [2:0]                            o_out_dir,
  input  logic                                  i_out_ready,
  output logic [NUM_VC*($clog2(DEPTH)+1)-1:0]   o_occupancy,
  output logic                                  o_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  localparam logic [2:0] VC_N = 3'd0;
  localparam logic [2:0] VC_S = 3'd1;
  localparam logic [2:0] VC_E = 3'd2;
  localparam logic [2:0] VC_W = 3'd3;
  localparam logic [2:0] VC_L = 3'd4;

  typedef enum logic {IN_IDLE, IN_PKT} in_state_e;
  typedef enum logic {ARB_FREE, ARB_LOCKED} arb_state_e;

  // XY routing: resolve X first, then Y, else deliver locally
  function automatic logic [2:0] calc_route(input logic [FLIT_W-1:0]  f,
                                            input logic [COORD_W-1:0] rx,
                                            input logic [COORD_W-1:0] ry);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = f[FLIT_W-3 -: COORD_W];
    dy = f[FLIT_W-3-COORD_W -: COORD_W];
    if (dx > rx)      return VC_E;
    else if (dx < rx) return VC_W;
    else if (dy > ry) return VC_N;
    else if (dy < ry) return VC_S;
    else              return VC_L;
  endfunction

  // FIFO storage and pointers
  logic [FLIT_W-1:0] r_mem    [NUM_VC][DEPTH];
  logic [PW-1:0]     r_wr_ptr [NUM_VC];
  logic [PW-1:0]     r_rd_ptr [NUM_VC];
  logic [CW-1:0]     r_count  [NUM_VC];

  // input-side FSM
  in_state_e   r_in_state, w_in_state_nxt;
  logic [2:0]  r_route, w_route_nxt;
  logic [1:0]  w_in_type;
  logic [2:0]  w_calc_route;
  logic [2:0]  w_tgt;
  logic        w_drop;
  logic        w_in_ready;
  logic        w_push;
  logic        w_err_nxt;
  logic        r_err;

  // output-side arbiter
  arb_state_e  r_arb_state, w_arb_state_nxt;
  logic [2:0]  r_lock_vc, w_lock_vc_nxt;
  logic [2:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic        r_hold, w_hold_nxt;
  logic [2:0]  r_hold_vc, w_hold_vc_nxt;
  logic [2:0]  w_gnt_vc;
  logic [2:0]  w_rr_idx;
  logic        w_out_valid;
  logic        w_pop;
  logic [FLIT_W-1:0] w_head_flit;
  logic [NUM_VC-1:0] w_nonempty;
  logic [NUM_VC-1:0] w_push_vec;
  logic [NUM_VC-1:0] w_pop_vec;

  assign w_in_type    = i_in_flit[FLIT_W-1 -: 2];
  assign w_calc_route = calc_route(i_in_flit, i_router_x, i_router_y);

  // input route lock: next state, drop decision and ready
  always_comb begin
    w_in_state_nxt = r_in_state;
    w_route_nxt    = r_route;
    w_tgt          = w_calc_route;
    w_drop         = 1'b0;
    w_push         = 1'b0;
    w_err_nxt      = 1'b0;
    w_in_ready     = 1'b1;
    case (r_in_state)
      IN_IDLE: begin
        w_tgt  = w_calc_route;
        w_drop = (w_in_type == T_BODY) || (w_in_type == T_TAIL);
      end
      IN_PKT: begin
        w_tgt  = r_route;
        w_drop = (w_in_type == T_HEAD) || (w_in_type == T_SINGLE);
      end
      default: ;
    endcase
    // dropped flits are always consumed
    w_in_ready = w_drop || (r_count[w_tgt] < CW'(DEPTH));
    if (i_in_valid && w_in_ready) begin
      if (w_drop) begin
        w_err_nxt      = 1'b1;
        w_in_state_nxt = IN_IDLE;   // a head inside a packet aborts it
      end else begin
        w_push = 1'b1;
        if (r_in_state == IN_IDLE && w_in_type == T_HEAD) begin
          w_in_state_nxt = IN_PKT;
          w_route_nxt    = w_calc_route;
        end else if (r_in_state == IN_PKT && w_in_type == T_TAIL) begin
          w_in_state_nxt = IN_IDLE;
        end
      end
    end
  end

  always_comb begin
    for (int v = 0; v < int'(NUM_VC); v++) begin
      w_nonempty[v] = (r_count[v] != '0);
    end
  end

  // packet-locked round-robin arbiter
  always_comb begin
    w_arb_state_nxt = r_arb_state;
    w_lock_vc_nxt   = r_lock_vc;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_hold_nxt      = 1'b0;
    w_hold_vc_nxt   = r_hold_vc;
    w_gnt_vc        = '0;
    w_rr_idx        = '0;
    w_out_valid     = 1'b0;
    if (r_arb_state == ARB_LOCKED) begin
      w_gnt_vc    = r_lock_vc;
      w_out_valid = w_nonempty[r_lock_vc];
    end else if (r_hold) begin
      // keep a stalled grant stable until the crossbar takes it
      w_gnt_vc    = r_hold_vc;
      w_out_valid = 1'b1;
    end else begin
      // scan farthest-first so the nearest non-empty VC after the pointer wins
      for (int k = int'(NUM_VC); k >= 1; k--) begin
        w_rr_idx = 3'((int'(r_rr_ptr) + k) % int'(NUM_VC));
        if (w_nonempty[w_rr_idx]) begin
          w_gnt_vc    = w_rr_idx;
          w_out_valid = 1'b1;
        end
      end
    end
    w_head_flit = r_mem[w_gnt_vc][r_rd_ptr[w_gnt_vc]];
    w_pop       = w_out_valid && i_out_ready;
    if (w_pop) begin
      w_rr_ptr_nxt = w_gnt_vc;
      case (w_head_flit[FLIT_W-1 -: 2])
        T_HEAD: begin
          w_arb_state_nxt = ARB_LOCKED;
          w_lock_vc_nxt   = w_gnt_vc;
        end
        T_TAIL, T_SINGLE: w_arb_state_nxt = ARB_FREE;
        default: ;
      endcase
    end else if (w_out_valid && r_arb_state == ARB_FREE) begin
      w_hold_nxt    = 1'b1;
      w_hold_vc_nxt = w_gnt_vc;
    end
  end

  always_comb begin
    w_push_vec = '0;
    w_pop_vec  = '0;
    for (int v = 0; v < int'(NUM_VC); v++) begin
      w_push_vec[v] = w_push && (w_tgt == 3'(v));
      w_pop_vec[v]  = w_pop && (w_gnt_vc == 3'(v));
    end
  end

  // FSM and control state registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_in_state  <= IN_IDLE;
      r_route     <= '0;
      r_arb_state <= ARB_FREE;
      r_lock_vc   <= '0;
      r_rr_ptr    <= 3'(NUM_VC - 1);
      r_hold      <= 1'b0;
      r_hold_vc   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_in_state  <= w_in_state_nxt;
      r_route     <= w_route_nxt;
      r_arb_state <= w_arb_state_nxt;
      r_lock_vc   <= w_lock_vc_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_vc   <= w_hold_vc_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // FIFO pointers and fill counts
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int v = 0; v < int'(NUM_VC); v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
        r_count[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < int'(NUM_VC); v++) begin
        if (w_push_vec[v]) r_wr_ptr[v] <= r_wr_ptr[v] + PW'(1);
        if (w_pop_vec[v])  r_rd_ptr[v] <= r_rd_ptr[v] + PW'(1);
        if (w_push_vec[v] && !w_pop_vec[v])      r_count[v] <= r_count[v] + CW'(1);
        else if (!w_push_vec[v] && w_pop_vec[v]) r_count[v] <= r_count[v] - CW'(1);
      end
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge i_clk) begin
    for (int v = 0; v < int'(NUM_VC); v++) begin
      if (w_push_vec[v]) r_mem[v][r_wr_ptr[v]] <= i_in_flit;
    end
  end

  always_comb begin
    o_occupancy = '0;
    for (int v = 0; v < int'(NUM_VC); v++) begin
      o_occupancy[v*CW +: CW] = r_count[v];
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_out_flit  = w_out_valid ? w_head_flit : '0;
  assign o_out_dir   = w_gnt_vc;
  assign o_err       = r_err;

endmodule

// File: tb/tb_noc_input_port.sv
// tb_noc_input_port: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the input port.
module tb_noc_input_port;

  localparam int unsigned FLIT_W = 10;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned NUM_VC = 5;
  localparam int unsigned CW     = 6;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           rx, ry;
  logic                 in_valid;
  logic [FLIT_W-1:0]    in_flit;
  logic                 in_ready;
  logic                 out_valid;
  logic [FLIT_W-1:0]    out_flit;
  logic [2:0]           out_dir;
  logic                 out_ready;
  logic [NUM_VC*CW-1:0] occ;
  logic                 err;

  always #5 clk = ~clk;

  noc_input_port #(.FLIT_W(10), .COORD_W(2), .DEPTH(32), .NUM_VC(5)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_router_x  (rx),
    .i_router_y  (ry),
    .i_in_valid  (in_valid),
    .i_in_flit   (in_flit),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_out_flit  (out_flit),
    .o_out_dir   (out_dir),
    .i_out_ready (out_ready),
    .o_occupancy (occ),
    .o_err       (err)
  );

  int n_tests;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: one queue per VC plus packet/arbiter bookkeeping
  typedef logic [FLIT_W-1:0] flit_q_t [$];
  flit_q_t mq [NUM_VC];
  bit m_in_pkt;
  int m_route;
  bit m_locked;
  int m_lock_vc;
  int m_ptr;
  bit m_hold;
  int m_hold_vc;
  bit m_err;

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input int dx, input int dy, input int pl);
    return {t, 2'(dx), 2'(dy), 4'(pl)};
  endfunction

  function automatic int route_of(input logic [FLIT_W-1:0] f);
    int dx, dy;
    dx = int'(f[7:6]);
    dy = int'(f[5:4]);
    if (dx > int'(rx)) return 2;
    if (dx < int'(rx)) return 3;
    if (dy > int'(ry)) return 0;
    if (dy < int'(ry)) return 1;
    return 4;
  endfunction

  function automatic logic [NUM_VC*CW-1:0] exp_occ();
    logic [NUM_VC*CW-1:0] e;
    e = '0;
    for (int v = 0; v < int'(NUM_VC); v++) e[v*CW +: CW] = CW'(mq[v].size());
    return e;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < int'(NUM_VC); v++) mq[v].delete();
    m_in_pkt = 0; m_route = 0; m_locked = 0; m_lock_vc = 0;
    m_ptr = int'(NUM_VC) - 1; m_hold = 0; m_hold_vc = 0; m_err = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // one clock cycle: drive, check combinational outputs, clock, check state
  task automatic cycle(input bit v, input logic [FLIT_W-1:0] f, input bit ordy);
    bit headish, drop, e_rdy, e_ov, xfer, pop;
    int tgt, g, c;
    logic [FLIT_W-1:0] e_of, pf;
    in_valid = v; in_flit = f; out_ready = ordy;
    #1;
    headish = (f[9:8] == T_HEAD) || (f[9:8] == T_SINGLE);
    drop    = m_in_pkt ? headish : !headish;
    tgt     = m_in_pkt ? m_route : route_of(f);
    e_rdy   = drop || (mq[tgt].size() < int'(DEPTH));
    e_ov = 0; g = 0;
    if (m_locked) begin
      g = m_lock_vc; e_ov = (mq[g].size() != 0);
    end else if (m_hold) begin
      g = m_hold_vc; e_ov = 1;
    end else begin
      for (int k = 1; k <= int'(NUM_VC); k++) begin
        c = (m_ptr + k) % int'(NUM_VC);
        if (!e_ov && mq[c].size() != 0) begin g = c; e_ov = 1; end
      end
    end
    e_of = e_ov ? mq[g][0] : '0;
    check_eq("in_ready",  32'(in_ready),  32'(e_rdy));
    check_eq("out_valid", 32'(out_valid), 32'(e_ov));
    check_eq("out_flit",  32'(out_flit),  32'(e_of));
    check_eq("out_dir",   32'(out_dir),   32'(g));
    xfer = v && e_rdy;
    pop  = e_ov && ordy;
    @(posedge clk); #1;
    if (pop) begin
      pf = mq[g].pop_front();
      m_ptr = g;
      if (pf[9:8] == T_HEAD) begin m_locked = 1; m_lock_vc = g; end
      else if (pf[9:8] == T_TAIL || pf[9:8] == T_SINGLE) m_locked = 0;
      m_hold = 0;
    end else begin
      m_hold = e_ov && !m_locked;
      m_hold_vc = g;
    end
    m_err = xfer && drop;
    if (xfer) begin
      if (drop) m_in_pkt = 0;
      else begin
        mq[tgt].push_back(f);
        if (!m_in_pkt && f[9:8] == T_HEAD) begin m_in_pkt = 1; m_route = tgt; end
        else if (m_in_pkt && f[9:8] == T_TAIL) m_in_pkt = 0;
      end
    end
    check_eq("err",       32'(err), 32'(m_err));
    check_eq("occupancy", 32'(occ), 32'(exp_occ()));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    bit rv, ro;
    logic [1:0] t;
    n_tests = 0; n_fail = 0;
    rst = 1'b0; rx = 2'd1; ry = 2'd1;
    in_valid = 1'b0; in_flit = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    #1;
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_flit",  32'(out_flit),  32'd0);
    check_eq("rst_out_dir",   32'(out_dir),   32'd0);
    check_eq("rst_err",       32'(err),       32'd0);
    check_eq("rst_occ",       32'(occ),       32'd0);

    // routing: N, S, E, W, L from router (1,1)
    cycle(1, mk(T_SINGLE, 1, 2, 1), 0);
    cycle(1, mk(T_SINGLE, 1, 0, 2), 0);
    cycle(1, mk(T_SINGLE, 2, 1, 3), 0);
    cycle(1, mk(T_SINGLE, 0, 1, 4), 0);
    cycle(1, mk(T_SINGLE, 1, 1, 5), 0);
    check_eq("route_occ", 32'(occ), 32'({5{6'd1}}));
    for (int k = 0; k < 5; k++) begin
      out_ready = 1'b1; #1;
      check_eq("route_drain_dir", 32'(out_dir), 32'(k));
      cycle(0, '0, 1);
    end

    // wormhole lock: body/tail address bits point west but follow the head
    cycle(1, mk(T_HEAD, 2, 1, 0), 0);
    for (int k = 1; k <= 3; k++) cycle(1, mk(T_BODY, 0, 1, k), 0);
    cycle(1, mk(T_TAIL, 0, 1, 4), 0);
    check_eq("worm_occ_e", 32'(occ[2*CW +: CW]), 32'd5);
    check_eq("worm_occ_w", 32'(occ[3*CW +: CW]), 32'd0);
    for (int k = 0; k < 6; k++) cycle(0, '0, 1);

    // full VC and backpressure, then push+pop across the wrap point
    for (int k = 0; k < 32; k++) cycle(1, mk(T_SINGLE, 1, 2, k), 0);
    check_eq("full_occ", 32'(occ[0 +: CW]), 32'd32);
    in_valid = 1'b1; in_flit = mk(T_SINGLE, 1, 2, 0); out_ready = 1'b0; #1;
    check_eq("full_ready", 32'(in_ready), 32'd0);
    cycle(1, mk(T_SINGLE, 1, 2, 0), 0);
    for (int k = 0; k < 40; k++) cycle(1, mk(T_SINGLE, 1, 2, k + 3), 1);
    check_eq("full_pushpop_occ", 32'(occ[0 +: CW]), 32'd31);
    for (int k = 0; k < 34; k++) cycle(0, '0, 1);

    // packet-locked round robin
    cycle(1, mk(T_HEAD, 1, 0, 1), 0);
    cycle(1, mk(T_BODY, 1, 0, 2), 0);
    cycle(1, mk(T_TAIL, 1, 0, 3), 0);
    cycle(1, mk(T_HEAD, 2, 1, 4), 0);
    cycle(1, mk(T_BODY, 2, 1, 5), 0);
    cycle(1, mk(T_TAIL, 2, 1, 6), 0);
    for (int k = 0; k < 6; k++) begin
      out_ready = 1'b1; #1;
      check_eq("rr_pkt_dir", 32'(out_dir), (k < 3) ? 32'd1 : 32'd2);
      cycle(0, '0, 1);
    end
    cycle(1, mk(T_SINGLE, 0, 1, 7), 0);
    cycle(1, mk(T_SINGLE, 1, 1, 8), 0);
    cycle(1, mk(T_SINGLE, 1, 2, 9), 0);
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'b1; #1;
      check_eq("rr_next_dir", 32'(out_dir), (k == 0) ? 32'd3 : (k == 1) ? 32'd4 : 32'd0);
      cycle(0, '0, 1);
    end

    // protocol errors
    cycle(1, mk(T_BODY, 1, 1, 0), 0);
    check_eq("err_body_idle", 32'(err), 32'd1);
    cycle(0, '0, 0);
    check_eq("err_pulse_end", 32'(err), 32'd0);
    cycle(1, mk(T_HEAD, 0, 1, 1), 0);
    cycle(1, mk(T_HEAD, 2, 1, 2), 0);
    check_eq("err_head_in_pkt", 32'(err), 32'd1);
    check_eq("err_head_not_written", 32'(occ[2*CW +: CW]), 32'd0);
    cycle(1, mk(T_BODY, 2, 1, 3), 0);
    check_eq("err_back_to_idle", 32'(err), 32'd1);

    // reset in the middle of a packet
    do_reset();
    cycle(1, mk(T_HEAD, 1, 0, 1), 0);
    cycle(1, mk(T_BODY, 1, 0, 2), 0);
    do_reset();
    #1;
    check_eq("midrst_occ",       32'(occ),       32'd0);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    cycle(1, mk(T_BODY, 1, 0, 3), 0);
    check_eq("midrst_body_err", 32'(err), 32'd1);

    // randomized traffic
    do_reset();
    rx = 2'($urandom_range(0, 3));
    ry = 2'($urandom_range(0, 3));
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      r = int'($urandom_range(0, 99));
      if (m_in_pkt) t = (r < 60) ? T_BODY : (r < 85) ? T_TAIL : (r < 95) ? T_SINGLE : T_HEAD;
      else          t = (r < 50) ? T_HEAD : (r < 90) ? T_SINGLE : (r < 95) ? T_BODY : T_TAIL;
      rv = ($urandom_range(0, 3) != 0);
      ro = ($urandom_range(0, 3) != 0);
      cycle(rv, mk(t, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 15))), ro);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
